// File: rtl/clint_arb.sv
// Two-master arbiter in front of the CLINT timer registers: one transaction at a
// time through IDLE -> ACCESS -> RESP, plus the registered timer interrupt.
module clint_arb #(
  parameter int              XLEN               = 32,
  parameter bit              FIXED_PRIO         = 1'b0,
  parameter logic [XLEN-1:0] MTIME_ADDR_LOW     = 'h0200_BFF8,
  parameter logic [XLEN-1:0] MTIME_ADDR_HIGH    = 'h0200_BFFC,
  parameter logic [XLEN-1:0] MTIMECMP_ADDR_LOW  = 'h0200_4000,
  parameter logic [XLEN-1:0] MTIMECMP_ADDR_HIGH = 'h0200_4004
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req_valid_i,
  output logic            m0_req_ready_o,
  input  logic [XLEN-1:0] m0_addr_i,
  input  logic            m0_we_i,
  input  logic [XLEN-1:0] m0_wdata_i,
  output logic            m0_rsp_valid_o,
  input  logic            m0_rsp_ready_i,
  output logic [XLEN-1:0] m0_rdata_o,
  output logic            m0_err_o,
  input  logic            m1_req_valid_i,
  output logic            m1_req_ready_o,
  input  logic [XLEN-1:0] m1_addr_i,
  input  logic            m1_we_i,
  input  logic [XLEN-1:0] m1_wdata_i,
  output logic            m1_rsp_valid_o,
  input  logic            m1_rsp_ready_i,
  output logic [XLEN-1:0] m1_rdata_o,
  output logic            m1_err_o,
  output logic [XLEN-1:0] tmr_addr_o,
  output logic            tmr_write_valid_o,
  output logic [XLEN-1:0] tmr_wdata_o,
  input  logic [XLEN-1:0] tmr_rdata_i,
  input  logic            tmr_ge_i,
  output logic            mtip_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state_q, state_d;
  logic            gnt_q, last_grant_q;
  logic            win, accept;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic            we_q, err_q, mtip_q;
  logic            in_access, in_resp, legal, is_cmp, rsp_ready;

  // On a tie the master that did not win last time goes first.
  always_comb begin
    if (m0_req_valid_i && m1_req_valid_i) win = FIXED_PRIO ? 1'b0 : ~last_grant_q;
    else                                  win = ~m0_req_valid_i;
  end

  // Ready is gated by rst so that every output is quiet while reset is held.
  assign accept         = (state_q == IDLE) && !rst && (m0_req_valid_i || m1_req_valid_i);
  assign m0_req_ready_o = accept && !win;
  assign m1_req_ready_o = accept && win;

  assign is_cmp    = (addr_q == MTIMECMP_ADDR_LOW) || (addr_q == MTIMECMP_ADDR_HIGH);
  assign legal     = is_cmp || (addr_q == MTIME_ADDR_LOW) || (addr_q == MTIME_ADDR_HIGH);
  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);
  assign rsp_ready = gnt_q ? m1_rsp_ready_i : m0_rsp_ready_i;

  assign tmr_addr_o        = in_access ? addr_q  : '0;
  assign tmr_wdata_o       = in_access ? wdata_q : '0;
  assign tmr_write_valid_o = in_access && we_q && legal;

  assign m0_rsp_valid_o = in_resp && !gnt_q;
  assign m1_rsp_valid_o = in_resp && gnt_q;
  assign m0_rdata_o     = m0_rsp_valid_o ? rdata_q : '0;
  assign m1_rdata_o     = m1_rsp_valid_o ? rdata_q : '0;
  assign m0_err_o       = m0_rsp_valid_o && err_q;
  assign m1_err_o       = m1_rsp_valid_o && err_q;
  assign mtip_o         = mtip_q;

  // NOTE: next state gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = ACCESS;
      ACCESS:                 state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      mtip_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      // A fresh mtimecmp write makes the compare result stale for one cycle.
      mtip_q  <= (in_access && we_q && is_cmp) ? 1'b0 : tmr_ge_i;
      if (accept) begin
        gnt_q        <= win;
        last_grant_q <= win;
        addr_q       <= win ? m1_addr_i  : m0_addr_i;
        we_q         <= win ? m1_we_i    : m0_we_i;
        wdata_q      <= win ? m1_wdata_i : m0_wdata_i;
      end
      if (in_access) begin
        rdata_q <= (we_q || !legal) ? '0 : tmr_rdata_i;
        err_q   <= !legal;
      end
    end
  end

endmodule

// File: tb/tb_clint_arb.sv
// Self-checking bench for clint_arb: directed scenarios then random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_clint_arb;
  localparam int          XLEN     = 32;
  localparam bit          FIXED    = 1'b0;
  localparam logic [31:0] A_MT_LO  = 32'h0200_BFF8;
  localparam logic [31:0] A_MT_HI  = 32'h0200_BFFC;
  localparam logic [31:0] A_CMP_LO = 32'h0200_4000;
  localparam logic [31:0] A_CMP_HI = 32'h0200_4004;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      m_valid, m_we, m_rready;
  logic [XLEN-1:0] m_addr0, m_addr1, m_wdata0, m_wdata1;
  logic [XLEN-1:0] tmr_rdata;
  logic            tmr_ge;
  logic [1:0]      req_ready, rsp_valid, rsp_err;
  logic [XLEN-1:0] rdata0, rdata1, tmr_addr, tmr_wdata;
  logic            tmr_wv, mtip;

  always #5 clk = ~clk;

  clint_arb #(.XLEN(XLEN), .FIXED_PRIO(FIXED)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid_i(m_valid[0]), .m0_req_ready_o(req_ready[0]), .m0_addr_i(m_addr0),
    .m0_we_i(m_we[0]), .m0_wdata_i(m_wdata0), .m0_rsp_valid_o(rsp_valid[0]),
    .m0_rsp_ready_i(m_rready[0]), .m0_rdata_o(rdata0), .m0_err_o(rsp_err[0]),
    .m1_req_valid_i(m_valid[1]), .m1_req_ready_o(req_ready[1]), .m1_addr_i(m_addr1),
    .m1_we_i(m_we[1]), .m1_wdata_i(m_wdata1), .m1_rsp_valid_o(rsp_valid[1]),
    .m1_rsp_ready_i(m_rready[1]), .m1_rdata_o(rdata1), .m1_err_o(rsp_err[1]),
    .tmr_addr_o(tmr_addr), .tmr_write_valid_o(tmr_wv), .tmr_wdata_o(tmr_wdata),
    .tmr_rdata_i(tmr_rdata), .tmr_ge_i(tmr_ge), .mtip_o(mtip)
  );

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction, described by its age in cycles.
  bit          busy = 0;
  int          age = 0, cur = 0, last = 1;
  logic [31:0] cur_addr, cur_wdata, exp_rdata;
  bit          cur_we, exp_err, exp_mtip = 0;
  int          issued[2] = '{0, 0};
  int          done[2]   = '{0, 0};
  bit          keep[2]   = '{0, 0};
  int          grants[$];

  function automatic bit is_cmp(input logic [31:0] a);
    return (a == A_CMP_LO) || (a == A_CMP_HI);
  endfunction

  function automatic bit legal(input logic [31:0] a);
    return is_cmp(a) || (a == A_MT_LO) || (a == A_MT_HI);
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return A_MT_LO;
      1:       return A_MT_HI;
      2:       return A_CMP_LO;
      3:       return A_CMP_HI;
      default: return $urandom();
    endcase
  endfunction

  task automatic new_req(input int i, input logic [31:0] a, input bit we, input logic [31:0] wd);
    m_valid[i] = 1'b1;
    m_we[i]    = we;
    if (i == 0) begin m_addr0 = a; m_wdata0 = wd; end
    else        begin m_addr1 = a; m_wdata1 = wd; end
    issued[i]++;
  endtask

  // Called at posedge+1 with inputs set; checks this cycle, then advances one edge.
  task automatic tick();
    logic [1:0]  e_rdy;
    logic [31:0] e_taddr, e_twd;
    bit          e_twv, e_rv, acc;
    int          win;
    for (int i = 0; i < 2; i++)
      if (keep[i] && !m_valid[i]) new_req(i, rand_addr(), 1'b0, 32'h0);
    #1;
    e_rdy = 2'b00; acc = 0; win = 0;
    if (!rst && !busy && m_valid != 2'b00) begin
      if (m_valid == 2'b11) win = FIXED ? 0 : 1 - last;
      else                  win = m_valid[1] ? 1 : 0;
      e_rdy[win] = 1'b1;
      acc = 1;
    end
    check("m0_req_ready", req_ready[0], e_rdy[0]);
    check("m1_req_ready", req_ready[1], e_rdy[1]);
    e_taddr = 0; e_twd = 0; e_twv = 0;
    if (!rst && busy && age == 1) begin
      e_taddr = cur_addr; e_twd = cur_wdata; e_twv = cur_we && legal(cur_addr);
    end
    check("tmr_addr", tmr_addr, e_taddr);
    check("tmr_wdata", tmr_wdata, e_twd);
    check("tmr_write_valid", tmr_wv, e_twv);
    for (int i = 0; i < 2; i++) begin
      e_rv = !rst && busy && age >= 2 && cur == i;
      check($sformatf("m%0d_rsp_valid", i), rsp_valid[i], e_rv);
      if (e_rv) begin
        check($sformatf("m%0d_rdata", i), (i == 0) ? rdata0 : rdata1, exp_rdata);
        check($sformatf("m%0d_err", i), rsp_err[i], exp_err);
      end
    end
    check("mtip", mtip, rst ? 1'b0 : exp_mtip);
    @(posedge clk);
    if (rst) begin
      if (busy) issued[cur]--;
      busy = 0; age = 0; last = 1; exp_mtip = 0;
    end else begin
      exp_mtip = (busy && age == 1 && cur_we && is_cmp(cur_addr)) ? 1'b0 : tmr_ge;
      if (busy && age == 1) begin
        exp_rdata = (cur_we || !legal(cur_addr)) ? 32'h0 : tmr_rdata;
        exp_err   = !legal(cur_addr);
      end
      if (busy && age >= 2 && m_rready[cur]) begin busy = 0; age = 0; done[cur]++; end
      else if (busy) age++;
      if (acc) begin
        busy = 1; age = 1; cur = win; last = win;
        cur_addr  = win ? m_addr1 : m_addr0;
        cur_wdata = win ? m_wdata1 : m_wdata0;
        cur_we    = m_we[win];
        grants.push_back(win);
      end
    end
    #1;
    if (acc) m_valid[win] = 1'b0;
  endtask

  task automatic drain();
    m_rready = 2'b11;
    for (int k = 0; k < 50 && (busy || m_valid != 2'b00); k++) tick();
    check("drain_idle", {busy, m_valid}, 3'b000);
  endtask

  initial begin
    rst = 1'b1; m_valid = 2'b00; m_we = 2'b00; m_rready = 2'b11;
    m_addr0 = '0; m_addr1 = '0; m_wdata0 = '0; m_wdata1 = '0;
    tmr_rdata = '0; tmr_ge = 1'b0;
    #1;
    tick(); tick();

    // Single read, first request right after reset release.
    rst = 1'b0;
    new_req(0, A_MT_LO, 1'b0, 32'h0);
    tmr_rdata = 32'h1234;
    tick(); tick();
    check("single_rsp_valid", rsp_valid[0], 1'b1);
    check("single_rdata", rdata0, 32'h1234);
    check("single_err", rsp_err[0], 1'b0);
    drain();

    // Contention from reset: both masters keep a request pending.
    rst = 1'b1;
    tick();
    grants.delete();
    keep = '{1, 1};
    rst = 1'b0;
    repeat (16) tick();
    keep = '{0, 0};
    drain();
    check("contention_count", grants.size() >= 4, 1'b1);
    if (grants.size() >= 4) begin
      check("contention_g0", grants[0], 0);
      check("contention_g1", grants[1], 1);
      check("contention_g2", grants[2], 0);
      check("contention_g3", grants[3], 1);
    end

    // Illegal address write from m1.
    new_req(1, 32'h0, 1'b1, 32'hDEAD_BEEF);
    tick(); tick();
    check("illegal_err", rsp_err[1], 1'b1);
    check("illegal_rdata", rdata1, 32'h0);
    drain();

    // Backpressure on m0 while m1 waits.
    m_rready = 2'b10;
    new_req(0, A_MT_HI, 1'b0, 32'h0);
    tmr_rdata = 32'hA5A5_0001;
    tick();
    new_req(1, A_CMP_HI, 1'b0, 32'h0);
    tick();
    tmr_rdata = 32'hFFFF_0000;
    repeat (5) begin
      check("bp_rsp_valid", rsp_valid[0], 1'b1);
      check("bp_rdata", rdata0, 32'hA5A5_0001);
      check("bp_m1_ready", req_ready[1], 1'b0);
      tick();
    end
    drain();
    check("bp_m1_done", done[1], issued[1]);

    // Interrupt masked for one cycle after an mtimecmp write.
    tmr_ge = 1'b1;
    tick(); tick();
    check("irq_before", mtip, 1'b1);
    new_req(0, A_CMP_LO, 1'b1, 32'h100);
    tick(); tick();
    check("irq_masked", mtip, 1'b0);
    tick();
    check("irq_after", mtip, 1'b1);
    drain();
    tmr_ge = 1'b0;

    // Reset during ACCESS abandons the write.
    new_req(1, A_MT_LO, 1'b1, 32'h55);
    tick();
    rst = 1'b1;
    #1;
    check("rst_access_wv", tmr_wv, 1'b0);
    check("rst_access_addr", tmr_addr, 32'h0);
    tick();
    rst = 1'b0;
    new_req(0, A_MT_LO, 1'b0, 32'h0);
    tick();
    drain();

    // Random traffic.
    repeat (400) begin
      for (int i = 0; i < 2; i++)
        if (!m_valid[i] && $urandom_range(0, 2) == 0)
          new_req(i, rand_addr(), 1'($urandom_range(0, 1)), $urandom());
      m_rready  = 2'($urandom_range(0, 3));
      tmr_rdata = $urandom();
      tmr_ge    = 1'($urandom_range(0, 1));
      tick();
    end
    drain();
    check("m0_all_done", done[0], issued[0]);
    check("m1_all_done", done[1], issued[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/clint_arb.md
CLINT_ARB -- requirements
Module: clint_arb

Parameters
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data/address width; it matches the codebase `XLEN.
REQ-002 The block SHALL have parameter FIXED_PRIO, default 0; 0 selects round-robin, 1 selects fixed priority with m0 winning.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have ports mN_req_valid_i, input, 1 bit (N=0,1): requester N presents a request.
REQ-006 The block SHALL have ports mN_req_ready_o, output, 1 bit: request N is accepted this cycle.
REQ-007 The block SHALL have ports mN_addr_i, input, XLEN bits: target register address.
REQ-008 The block SHALL have ports mN_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have ports mN_wdata_i, input, XLEN bits: write data.
REQ-010 The block SHALL have ports mN_rsp_valid_o, output, 1 bit: response for requester N is available.
REQ-011 The block SHALL have ports mN_rsp_ready_i, input, 1 bit: requester N consumes the response.
REQ-012 The block SHALL have ports mN_rdata_o, output, XLEN bits: read data; 0 for writes and errors.
REQ-013 The block SHALL have ports mN_err_o, output, 1 bit, valid with rsp_valid: the address was not MTIME_ADDR_LOW/HIGH or MTIMECMP_ADDR_LOW/HIGH.
REQ-014 The block SHALL have port tmr_addr_o, output, XLEN bits: address to the timer block.
REQ-015 The block SHALL have port tmr_write_valid_o, output, 1 bit: timer write strobe.
REQ-016 The block SHALL have port tmr_wdata_o, output, XLEN bits: timer write data.
REQ-017 The block SHALL have port tmr_rdata_i, input, XLEN bits: timer combinational read data.
REQ-018 The block SHALL have port tmr_ge_i, input, 1 bit: timer mtime >= mtimecmp.
REQ-019 The block SHALL have port mtip_o, output, 1 bit: registered machine timer interrupt pending.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS and RESP, one-hot or encoded, plus a registered grant index gnt (0/1).
REQ-021 In IDLE, the block SHALL arbitrate among the asserted mN_req_valid_i and assert mN_req_ready_o combinationally for the winner only, then capture addr/we/wdata/gnt and go to ACCESS.
REQ-022 The ready outputs SHALL be 0 in ACCESS and RESP; a requester SHALL hold valid and payload stable until ready.
REQ-023 In round-robin mode, on a tie the requester not granted last SHALL win; last_grant SHALL reset to 1, so m0 wins the first tie.
REQ-024 In ACCESS, for exactly one cycle, tmr_addr_o SHALL be the captured address, tmr_write_valid_o SHALL be we AND a legal address, and tmr_rdata_i SHALL be captured into the response register (forced to 0 if we or illegal); the FSM then moves to RESP.
REQ-025 tmr_write_valid_o SHALL be 0 in every state other than ACCESS; tmr_addr_o and tmr_wdata_o SHALL be 0 outside ACCESS.
REQ-026 In RESP, only the granted mN_rsp_valid_o SHALL be 1 with rdata/err held stable; the FSM SHALL return to IDLE on the cycle mN_rsp_ready_i=1.
REQ-027 Timing SHALL be: request accepted at cycle T, timer access at T+1, rsp_valid from T+2; best-case throughput is one transaction per 3 cycles.
REQ-028 An illegal address SHALL complete normally through all states with err=1, rdata=0 and no timer write.
REQ-029 mtip_o SHALL be tmr_ge_i registered, except it SHALL be forced to 0 in the cycle after an ACCESS-state write to MTIMECMP_ADDR_LOW/HIGH, to hide the stale compare.
REQ-030 A request arriving while busy SHALL wait; no request is dropped and none is granted twice.

Reset
REQ-031 On rst=1, asynchronously, the block SHALL set state=IDLE, gnt=0, last_grant=1, the response registers to 0, and mtip_o=0.
REQ-032 All outputs SHALL be 0 during reset; a transaction in flight at reset SHALL be abandoned without a timer write.
REQ-033 After rst is released, the first request SHALL be accepted in the first IDLE cycle.

Verification
REQ-034 Single read: m0 reads MTIME_ADDR_LOW at T with tmr_rdata_i=0x1234 -> m0_rsp_valid_o=1 at T+2 with rdata=0x1234 and err=0.
REQ-035 Contention: m0 and m1 hold valid continuously from reset (FIXED_PRIO=0) -> grants alternate m0, m1, m0, m1.
REQ-036 Illegal address: m1 writes 0x0 -> err=1, rdata=0, tmr_write_valid_o never asserted.
REQ-037 Backpressure: m0_rsp_ready_i held 0 for 5 cycles -> rsp_valid and rdata stay stable, m1 is not granted, and m1 completes after m0's response is consumed.
REQ-038 Interrupt: write MTIMECMP_ADDR_LOW while tmr_ge_i=1 -> mtip_o=0 for one cycle, then follows tmr_ge_i.
REQ-039 Reset in ACCESS: assert rst during the ACCESS state -> outputs go to 0 immediately, there is no response, and the next request starts at the IDLE timing.
